// File: rtl/music_sched_pkg.sv
// Shared encodings and widths for the music scheduler.
package music_sched_pkg;

  localparam int unsigned BEAT_W       = 12;
  localparam int unsigned TRACK_W      = 3;
  localparam int unsigned VOL_W        = 2;
  localparam int unsigned BGM_LAST_DEF = 1200;

  localparam logic [TRACK_W-1:0] TRACK_BGM = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BGM  = 2'd1,
    ST_SFX  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/music_scheduler_req_sync_edge.sv
// Two-flop synchroniser with rising-edge detect on the synchronised value.
module req_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk22,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync   = sync_q;
  assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/music_scheduler.sv
// Arbitrates the audio datapath between looping BGM and prioritised SFX requests.
module music_scheduler
  import music_sched_pkg::*;
#(
  parameter int unsigned     BGM_LAST = BGM_LAST_DEF,
  parameter int unsigned     SFX_LEN  = 64,
  parameter int unsigned     N_SFX    = 4,
  parameter logic [VOL_W-1:0] SFX_VOL = 2'b11
) (
  input  logic               clk22,
  input  logic               rst,
  input  logic               music_en,
  input  logic [VOL_W-1:0]   volume_sw,
  input  logic [N_SFX-1:0]   sfx_req,
  output logic [BEAT_W-1:0]  beat_num,
  output logic [TRACK_W-1:0] track_sel,
  output logic               play_en,
  output logic [VOL_W-1:0]   volume_out,
  output logic [N_SFX-1:0]   sfx_ack,
  output logic [1:0]         sched_state
);

  if (BGM_LAST >= 4096) begin : g_bad_bgm_last
    $error("BGM_LAST must fit in a 12-bit beat index");
  end
  if (SFX_LEN > 4096 || SFX_LEN == 0) begin : g_bad_sfx_len
    $error("SFX_LEN must be in 1..4096");
  end
  if (N_SFX > 7 || N_SFX == 0) begin : g_bad_n_sfx
    $error("N_SFX must be in 1..7");
  end

  logic [N_SFX-1:0] req_sync_unused;
  logic [N_SFX-1:0] req_rise_c;
  logic [2:0]       cfg_s;
  logic [2:0]       cfg_rise_unused;
  logic             music_en_s;
  logic [VOL_W-1:0] vol_s;

  req_sync_edge #(.W(N_SFX)) u_req_sync (
    .clk22  (clk22),
    .rst    (rst),
    .d      (sfx_req),
    .sync   (req_sync_unused),
    .rise_c (req_rise_c)
  );

  req_sync_edge #(.W(3)) u_cfg_sync (
    .clk22  (clk22),
    .rst    (rst),
    .d      ({music_en, volume_sw}),
    .sync   (cfg_s),
    .rise_c (cfg_rise_unused)
  );

  assign music_en_s = cfg_s[2];
  assign vol_s      = cfg_s[1:0];

  sched_state_e       state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d, bgm_next;
  logic [TRACK_W-1:0] track_q, track_d;
  logic               play_q, play_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic [N_SFX-1:0]   ack_q, ack_d;
  logic [TRACK_W-1:0] id_q, id_d;
  logic [BEAT_W-1:0]  saved_q, saved_d;
  logic               resume_q, resume_d;
  logic [N_SFX-1:0]   pending_q, pending_d;
  logic [N_SFX-1:0]   grant_c;
  logic               pend_any;
  logic [TRACK_W-1:0] pend_idx;
  logic [N_SFX-1:0]   pend_oh;
  logic               do_start;
  logic               do_idle;

  // Fixed-priority encoder: lowest pending index wins.
  always_comb begin
    pend_any = |pending_q;
    pend_idx = '0;
    pend_oh  = '0;
    for (int i = 0; i < int'(N_SFX); i++) begin
      if (pending_q[i] && (pend_oh == '0)) begin
        pend_idx   = TRACK_W'(i);
        pend_oh[i] = 1'b1;
      end
    end
  end

  // Request edges latch into pending; a grant clears its bit unless a fresh edge arrives.
  assign pending_d = (pending_q & ~grant_c) | req_rise_c;

  // Next-state and next-output logic for the IDLE/BGM/SFX sequencer.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    track_d  = track_q;
    play_d   = play_q;
    vol_d    = vol_q;
    ack_d    = '0;
    id_d     = id_q;
    saved_d  = saved_q;
    resume_d = resume_q;
    grant_c  = '0;
    do_start = 1'b0;
    do_idle  = 1'b0;
    bgm_next = (beat_q == BEAT_W'(BGM_LAST)) ? '0 : beat_q + BEAT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (pend_any) begin
          do_start = 1'b1;
          resume_d = 1'b0;
        end else if (music_en_s) begin
          state_d = ST_BGM;
          beat_d  = '0;
          track_d = TRACK_BGM;
          play_d  = 1'b1;
          vol_d   = vol_s;
        end else begin
          do_idle = 1'b1;
        end
      end
      ST_BGM: begin
        if (pend_any) begin
          do_start = 1'b1;
          saved_d  = bgm_next;
          resume_d = 1'b1;
        end else if (!music_en_s) begin
          do_idle = 1'b1;
        end else begin
          beat_d = bgm_next;
          vol_d  = vol_s;
        end
      end
      ST_SFX: begin
        if (!music_en_s) begin
          resume_d = 1'b0;
        end
        if (pend_any && (pend_idx < id_q)) begin
          do_start = 1'b1;
        end else if (beat_q == BEAT_W'(SFX_LEN - 1)) begin
          if (pend_any) begin
            do_start = 1'b1;
          end else if (resume_q && music_en_s) begin
            state_d  = ST_BGM;
            beat_d   = saved_q;
            track_d  = TRACK_BGM;
            play_d   = 1'b1;
            vol_d    = vol_s;
            resume_d = 1'b0;
          end else begin
            do_idle = 1'b1;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        do_idle = 1'b1;
      end
    endcase

    if (do_start) begin
      state_d = ST_SFX;
      id_d    = pend_idx;
      beat_d  = '0;
      track_d = pend_idx + TRACK_W'(1);
      play_d  = 1'b1;
      vol_d   = SFX_VOL;
      ack_d   = pend_oh;
      grant_c = pend_oh;
    end

    if (do_idle) begin
      state_d  = ST_IDLE;
      beat_d   = '0;
      track_d  = TRACK_BGM;
      play_d   = 1'b0;
      vol_d    = '0;
      resume_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, pending bits and BGM resume context.
  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      beat_q    <= '0;
      track_q   <= '0;
      play_q    <= 1'b0;
      vol_q     <= '0;
      ack_q     <= '0;
      id_q      <= '0;
      saved_q   <= '0;
      resume_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      beat_q    <= beat_d;
      track_q   <= track_d;
      play_q    <= play_d;
      vol_q     <= vol_d;
      ack_q     <= ack_d;
      id_q      <= id_d;
      saved_q   <= saved_d;
      resume_q  <= resume_d;
      pending_q <= pending_d;
    end
  end

  assign beat_num    = beat_q;
  assign track_sel   = track_q;
  assign play_en     = play_q;
  assign volume_out  = vol_q;
  assign sfx_ack     = ack_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_music_scheduler.sv
// Directed plus randomized bench for music_scheduler against a beat-level reference model.
module tb_music_scheduler;

  localparam int N        = 4;
  localparam int BGM_LAST = 1200;
  localparam int SFX_LEN  = 64;
  localparam int SFX_VOL  = 3;

  logic         clk22 = 1'b0;
  logic         rst;
  logic         music_en;
  logic [1:0]   volume_sw;
  logic [N-1:0] sfx_req;
  logic [11:0]  beat_num;
  logic [2:0]   track_sel;
  logic         play_en;
  logic [1:0]   volume_out;
  logic [N-1:0] sfx_ack;
  logic [1:0]   sched_state;

  music_scheduler #(
    .BGM_LAST (BGM_LAST),
    .SFX_LEN  (SFX_LEN),
    .N_SFX    (N),
    .SFX_VOL  (2'b11)
  ) dut (
    .clk22       (clk22),
    .rst         (rst),
    .music_en    (music_en),
    .volume_sw   (volume_sw),
    .sfx_req     (sfx_req),
    .beat_num    (beat_num),
    .track_sel   (track_sel),
    .play_en     (play_en),
    .volume_out  (volume_out),
    .sfx_ack     (sfx_ack),
    .sched_state (sched_state)
  );

  always #5 clk22 = ~clk22;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what is playing, where, and which requests are waiting.
  typedef struct {
    bit         en;
    bit [1:0]   vol;
    bit [N-1:0] req;
  } samp_t;

  samp_t      hist[$];
  int         m_mode;    // 0 silent, 1 music, 2 effect
  int         m_beat;
  int         m_id;
  int         m_saved;
  int         m_vol;
  bit         m_resume;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_ack;

  function automatic void model_reset();
    samp_t z;
    z.en = 1'b0; z.vol = 2'd0; z.req = '0;
    hist = {};
    for (int i = 0; i < 3; i++) hist.push_back(z);
    m_mode = 0; m_beat = 0; m_id = 0; m_saved = 0; m_vol = 0;
    m_resume = 1'b0; m_pend = '0; m_ack = '0;
  endfunction

  function automatic int lowest(bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One beat-clock edge: inputs seen by the scheduler lag the pins by two edges.
  function automatic void model_step(samp_t now);
    samp_t      sy, pr;
    bit [N-1:0] rise, grant;
    int         lo;
    bit         start, old_resume;
    sy    = hist[hist.size()-2];
    pr    = hist[hist.size()-3];
    rise  = sy.req & ~pr.req;
    lo    = lowest(m_pend);
    grant = '0;
    start = 1'b0;
    old_resume = m_resume;
    m_ack = '0;
    if (m_mode == 0) begin
      if (lo >= 0) begin
        start = 1'b1; m_resume = 1'b0;
      end else if (sy.en) begin
        m_mode = 1; m_beat = 0; m_vol = sy.vol;
      end
    end else if (m_mode == 1) begin
      if (lo >= 0) begin
        m_saved = (m_beat == BGM_LAST) ? 0 : m_beat + 1;
        m_resume = 1'b1; start = 1'b1;
      end else if (!sy.en) begin
        m_mode = 0; m_beat = 0;
      end else begin
        m_beat = (m_beat == BGM_LAST) ? 0 : m_beat + 1;
        m_vol = sy.vol;
      end
    end else begin
      if (!sy.en) m_resume = 1'b0;
      if (lo >= 0 && lo < m_id) start = 1'b1;
      else if (m_beat == SFX_LEN - 1) begin
        if (lo >= 0) start = 1'b1;
        else if (old_resume && sy.en) begin
          m_mode = 1; m_beat = m_saved; m_vol = sy.vol; m_resume = 1'b0;
        end else begin
          m_mode = 0; m_beat = 0; m_resume = 1'b0;
        end
      end else m_beat = m_beat + 1;
    end
    if (start) begin
      m_mode = 2; m_id = lo; m_beat = 0;
      grant[lo] = 1'b1; m_ack = grant;
    end
    m_pend = (m_pend & ~grant) | rise;
    hist.push_back(now);
    if (hist.size() > 4) void'(hist.pop_front());
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int eb, et, ep, ev;
    eb = (m_mode == 0) ? 0 : m_beat;
    et = (m_mode == 2) ? m_id + 1 : 0;
    ep = (m_mode == 0) ? 0 : 1;
    ev = (m_mode == 1) ? m_vol : ((m_mode == 2) ? SFX_VOL : 0);
    check("beat_num", 16'(beat_num), 16'(eb));
    check("track_sel", 16'(track_sel), 16'(et));
    check("play_en", 16'(play_en), 16'(ep));
    check("volume_out", 16'(volume_out), 16'(ev));
    check("sfx_ack", 16'(sfx_ack), 16'(m_ack));
    check("sched_state", 16'(sched_state), 16'(m_mode));
  endtask

  // Advance one beat edge, update the model from the pins, then compare.
  task automatic tick();
    samp_t s;
    @(posedge clk22);
    s.en = music_en; s.vol = volume_sw; s.req = sfx_req;
    if (rst) model_reset();
    else model_step(s);
    #1;
    check_all();
  endtask

  task automatic pulse(input logic [N-1:0] m);
    sfx_req = m;
    tick();
    tick();
    sfx_req = '0;
  endtask

  int         hold_cnt[N];
  int         low_cnt[N];

  initial begin
    rst = 1'b1; music_en = 1'b0; volume_sw = 2'd0; sfx_req = '0;
    model_reset();
    tick();
    tick();
    check("rst_beat", 16'(beat_num), 16'd0);

    // Looping music with wrap at the last beat
    rst = 1'b0; music_en = 1'b1; volume_sw = 2'd2;
    repeat (3) tick();
    check("bgm_start_play", 16'(play_en), 16'd1);
    check("bgm_start_beat", 16'(beat_num), 16'd0);
    check("bgm_start_vol", 16'(volume_out), 16'd2);
    for (int k = 0; k < 1300 && !(m_mode == 1 && m_beat == BGM_LAST); k++) begin
      if ($urandom_range(0, 49) == 0) volume_sw = 2'($urandom);
      tick();
    end
    check("bgm_last", 16'(beat_num), 16'd1200);
    tick();
    check("bgm_wrap", 16'(beat_num), 16'd0);

    // Effect 2 preempts music at beat 500, then music resumes
    for (int k = 0; k < 1000 && m_beat != 500; k++) tick();
    check("bgm_500", 16'(beat_num), 16'd500);
    pulse(4'b0100);
    tick();
    tick();
    check("sfx2_ack", 16'(sfx_ack), 16'b0100);
    check("sfx2_track", 16'(track_sel), 16'd3);
    check("sfx2_vol", 16'(volume_out), 16'd3);
    check("sfx2_beat0", 16'(beat_num), 16'd0);
    repeat (63) tick();
    check("sfx2_last", 16'(beat_num), 16'd63);
    tick();
    check("resume_beat", 16'(beat_num), 16'd504);
    check("resume_track", 16'(track_sel), 16'd0);

    // Two simultaneous requests from silence, served back to back
    music_en = 1'b0;
    repeat (4) tick();
    check("idle_state", 16'(sched_state), 16'd0);
    pulse(4'b1010);
    tick();
    tick();
    check("dual_ack1", 16'(sfx_ack), 16'b0010);
    check("dual_track2", 16'(track_sel), 16'd2);
    repeat (64) tick();
    check("dual_ack3", 16'(sfx_ack), 16'b1000);
    check("dual_track4", 16'(track_sel), 16'd4);
    check("dual_beat0", 16'(beat_num), 16'd0);
    repeat (64) tick();
    check("dual_idle", 16'(play_en), 16'd0);

    // Lower index preempts a playing effect, which is then dropped
    pulse(4'b0100);
    tick();
    tick();
    check("pre_track3", 16'(track_sel), 16'd3);
    repeat (10) tick();
    check("pre_beat10", 16'(beat_num), 16'd10);
    pulse(4'b0001);
    tick();
    tick();
    check("pre_ack0", 16'(sfx_ack), 16'b0001);
    check("pre_track1", 16'(track_sel), 16'd1);
    check("pre_beat0", 16'(beat_num), 16'd0);
    repeat (64) tick();
    check("pre_no_resume", 16'(play_en), 16'd0);

    // Music switched off during an effect that interrupted it
    music_en = 1'b1;
    repeat (5) tick();
    check("off_bgm", 16'(sched_state), 16'd1);
    pulse(4'b1000);
    tick();
    tick();
    check("off_track4", 16'(track_sel), 16'd4);
    repeat (10) tick();
    music_en = 1'b0;
    repeat (53) tick();
    check("off_last_beat", 16'(beat_num), 16'd63);
    check("off_still_sfx", 16'(track_sel), 16'd4);
    tick();
    check("off_idle_play", 16'(play_en), 16'd0);
    check("off_idle_beat", 16'(beat_num), 16'd0);

    // Asynchronous reset in the middle of an effect
    music_en = 1'b1;
    pulse(4'b0010);
    tick();
    tick();
    repeat (5) tick();
    check("rst_pre_track", 16'(track_sel), 16'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_beat", 16'(beat_num), 16'd0);
    check("arst_track", 16'(track_sel), 16'd0);
    check("arst_play", 16'(play_en), 16'd0);
    check("arst_vol", 16'(volume_out), 16'd0);
    check("arst_ack", 16'(sfx_ack), 16'd0);
    check("arst_state", 16'(sched_state), 16'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    repeat (12) begin
      tick();
      check("arst_no_ack", 16'(sfx_ack), 16'd0);
    end

    // Random traffic: request pulses, music toggling, volume changes
    for (int i = 0; i < N; i++) begin
      hold_cnt[i] = 0;
      low_cnt[i]  = 2;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (sfx_req[i]) begin
          hold_cnt[i]--;
          if (hold_cnt[i] <= 0) begin
            sfx_req[i] = 1'b0;
            low_cnt[i] = int'($urandom_range(2, 40));
          end
        end else if (low_cnt[i] > 0) begin
          low_cnt[i]--;
        end else if ($urandom_range(0, 199) < 3) begin
          sfx_req[i]  = 1'b1;
          hold_cnt[i] = int'($urandom_range(2, 4));
        end
      end
      if ($urandom_range(0, 299) == 0) music_en = ~music_en;
      if ($urandom_range(0, 19) == 0) volume_sw = 2'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
